// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
//
// Round-robin arbiter that shares one registered valid/ready stream channel
// between N requesters at packet granularity. Once a requester wins, it owns
// the channel until it transfers a beat with last=1. The winning beat is
// captured into a single output register stage together with its source index.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_data    requester data, requester i at [i*DATA_W +: DATA_W]
//   in_valid   requester beat valid
//   in_last    requester beat is last of packet
//   in_ready   requester beat accepted this cycle (at most one bit set)
//   out_data   shared channel data (registered)
//   out_valid  shared channel valid (registered)
//   out_last   shared channel last (registered)
//   out_idx    source requester of the current out beat (registered)
//   out_ready  downstream accepts the out beat
//   busy       a packet is in progress or an out beat is pending
module stream_rr_arbiter #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic [N-1:0]        in_valid,
  input  logic [N-1:0]        in_last,
  output logic [N-1:0]        in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic                out_last,
  output logic [IDX_W-1:0]    out_idx,
  input  logic                out_ready,
  output logic                busy
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;

  logic                load_en;
  logic                accept;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    next_ptr;
  logic [IDX_W-1:0]    scan_idx;
  int unsigned         scan_sum;
  logic                found;
  logic [DATA_W-1:0]   in_data_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign in_data_arr[g] = in_data[g*DATA_W +: DATA_W];
  end

  // The output register can take a new beat when it is empty or being drained.
  assign load_en = !out_valid_q | out_ready;

  // Winner selection: the owner while locked, otherwise the first valid
  // requester scanning upward from ptr with wrap-around.
  always_comb begin
    winner   = lock_idx_q;
    found    = 1'b0;
    scan_sum = 0;
    scan_idx = '0;
    if (state_q == StLocked) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        scan_sum = int'(ptr_q) + k;
        if (scan_sum >= N) scan_sum = scan_sum - N;
        scan_idx = IDX_W'(scan_sum);
        if (!found && in_valid[scan_idx]) begin
          found  = 1'b1;
          winner = scan_idx;
        end
      end
    end
  end

  // in_ready is forced low while reset is asserted, since the empty output
  // register would otherwise advertise readiness.
  for (genvar g = 0; g < N; g++) begin : g_ready
    assign in_ready[g] = rst_n & load_en & found & (winner == IDX_W'(g)) &
                         ((state_q == StLocked) | in_valid[g]);
  end

  assign accept   = |(in_valid & in_ready);
  assign next_ptr = (winner == IDX_W'(N - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_idx_d  = lock_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    if (accept) begin
      out_data_d  = in_data_arr[winner];
      out_last_d  = in_last[winner];
      out_idx_d   = winner;
      out_valid_d = 1'b1;
      if (in_last[winner]) begin
        state_d = StIdle;
        ptr_d   = next_ptr;
      end else begin
        state_d    = StLocked;
        lock_idx_d = winner;
      end
    end else if (load_en) begin
      // Drained with nothing to replace it; payload regs keep their value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      lock_idx_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_idx_q  <= lock_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign busy      = (state_q == StLocked) | out_valid_q;

endmodule
